tick_gen: RTL and testbench

TICK_GEN -- requirements
Module: tick_gen

---
 rtl/TypesPkg.sv | 15 +
 rtl/tick_channel.sv | 136 +++++++++++++
 rtl/tick_gen.sv | 58 +++++
 tb/tb_tick_gen.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/TypesPkg.sv
// Shared type package for the tick generator.
// Defines tick_mode_t, the per-channel operating mode, and the width of the
// configuration channel index.
package TypesPkg;

  localparam int unsigned CFG_CH_W = 4;

  // A stored value of 3 is not listed and is treated as PERIODIC by the channel.
  typedef enum logic [1:0] {
    PERIODIC = 2'd0,
    ONESHOT  = 2'd1,
    STEP     = 2'd2
  } tick_mode_t;

endpackage

// File: rtl/tick_channel.sv
// One independent tick channel: divisor/mode registers, counter, one-shot
// armed flag, square wave and step_req edge history.
// Ports:
//   clk_i, reset_i     clock, synchronous active-high reset
//   cfg_we_i           configuration write aimed at this channel (decoded)
//   cfg_div_i          divisor to load
//   cfg_mode_i         mode to load
//   en_i               run enable
//   step_i             step/arm request level
//   tick_o             registered single-cycle tick pulse
//   sq_o               registered square wave, toggles on every tick
//   armed_o            one-shot armed status
module tick_channel
  import TypesPkg::*;
#(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned DEFAULT_DIV = 50_000_000
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             cfg_we_i,
  input  logic [CNT_W-1:0] cfg_div_i,
  input  tick_mode_t       cfg_mode_i,
  input  logic             en_i,
  input  logic             step_i,
  output logic             tick_o,
  output logic             sq_o,
  output logic             armed_o
);

  logic [CNT_W-1:0] div_q, div_d;
  tick_mode_t       mode_q, mode_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             armed_q, armed_d;
  logic             sq_q, sq_d;
  logic             tick_q, tick_d;
  logic             step_q, step_d;

  logic [CNT_W-1:0] term_cnt;
  logic             at_term;
  logic             step_edge;

  // Terminal count is E-1 with E = max(div, 1), so div = 0 aliases div = 1.
  always_comb begin
    term_cnt = '0;
    if (div_q != '0) begin
      term_cnt = div_q - CNT_W'(1);
    end
  end

  assign at_term   = (cnt_q == term_cnt);
  assign step_edge = step_i & ~step_q;

  // State register.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      div_q   <= CNT_W'(DEFAULT_DIV);
      mode_q  <= PERIODIC;
      cnt_q   <= '0;
      armed_q <= 1'b0;
      sq_q    <= 1'b0;
      tick_q  <= 1'b0;
      step_q  <= 1'b0;
    end else begin
      div_q   <= div_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      armed_q <= armed_d;
      sq_q    <= sq_d;
      tick_q  <= tick_d;
      step_q  <= step_d;
    end
  end

  // Next-state logic: config write beats enable, enable beats mode behaviour.
  always_comb begin
    div_d   = div_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    armed_d = armed_q;
    sq_d    = sq_q;
    tick_d  = 1'b0;
    // Edge history follows the input every cycle, whatever else happens.
    step_d  = step_i;

    if (cfg_we_i) begin
      div_d   = cfg_div_i;
      mode_d  = cfg_mode_i;
      cnt_d   = '0;
      armed_d = 1'b0;
    end else if (!en_i) begin
      cnt_d = '0;
    end else begin
      case (mode_q)
        ONESHOT: begin
          if (step_edge) begin
            // Arm, or retrigger if already armed.
            armed_d = 1'b1;
            cnt_d   = '0;
          end else if (armed_q) begin
            if (at_term) begin
              cnt_d   = '0;
              tick_d  = 1'b1;
              armed_d = 1'b0;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end else begin
            cnt_d = '0;
          end
        end
        STEP: begin
          cnt_d  = '0;
          tick_d = step_edge;
        end
        default: begin
          if (at_term) begin
            cnt_d  = '0;
            tick_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      endcase
    end

    if (tick_d) begin
      sq_d = ~sq_q;
    end
  end

  assign tick_o  = tick_q;
  assign sq_o    = sq_q;
  assign armed_o = armed_q;

endmodule

// File: rtl/tick_gen.sv
// Multi-channel programmable tick generator.
// Decodes configuration writes to a channel and instantiates NUM_CH
// independent tick_channel blocks, assembling their outputs into buses.
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   cfg_we       configuration write strobe
//   cfg_ch       target channel; indices >= NUM_CH are ignored
//   cfg_div      divisor to write
//   cfg_mode     mode to write
//   ch_en        per-channel run enable
//   step_req     per-channel step/arm request (rising-edge sensitive)
//   tick         per-channel tick pulse
//   sq           per-channel square wave
//   armed        per-channel one-shot armed status
module tick_gen
  import TypesPkg::*;
#(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned DEFAULT_DIV = 50_000_000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cfg_we,
  input  logic [CFG_CH_W-1:0] cfg_ch,
  input  logic [CNT_W-1:0]    cfg_div,
  input  tick_mode_t          cfg_mode,
  input  logic [NUM_CH-1:0]   ch_en,
  input  logic [NUM_CH-1:0]   step_req,
  output logic [NUM_CH-1:0]   tick,
  output logic [NUM_CH-1:0]   sq,
  output logic [NUM_CH-1:0]   armed
);

  logic [NUM_CH-1:0] ch_we;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    // Full-width compare so out-of-range indices never alias a real channel.
    assign ch_we[i] = cfg_we && (cfg_ch == CFG_CH_W'(i));

    tick_channel #(
      .CNT_W      (CNT_W),
      .DEFAULT_DIV(DEFAULT_DIV)
    ) u_ch (
      .clk_i     (clk),
      .reset_i   (reset),
      .cfg_we_i  (ch_we[i]),
      .cfg_div_i (cfg_div),
      .cfg_mode_i(cfg_mode),
      .en_i      (ch_en[i]),
      .step_i    (step_req[i]),
      .tick_o    (tick[i]),
      .sq_o      (sq[i]),
      .armed_o   (armed[i])
    );
  end

endmodule

// File: tb/tb_tick_gen.sv
// Directed self-checking bench for tick_gen (NUM_CH=4, DEFAULT_DIV=4).
module tb_tick_gen;
  import TypesPkg::*;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned CNT_W  = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic              cfg_we;
  logic [3:0]        cfg_ch;
  logic [CNT_W-1:0]  cfg_div;
  tick_mode_t        cfg_mode;
  logic [NUM_CH-1:0] ch_en;
  logic [NUM_CH-1:0] step_req;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] sq;
  logic [NUM_CH-1:0] armed;

  int n_chk = 0;
  int n_bad = 0;

  tick_gen #(
    .NUM_CH     (NUM_CH),
    .CNT_W      (CNT_W),
    .DEFAULT_DIV(4)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .cfg_we  (cfg_we),
    .cfg_ch  (cfg_ch),
    .cfg_div (cfg_div),
    .cfg_mode(cfg_mode),
    .ch_en   (ch_en),
    .step_req(step_req),
    .tick    (tick),
    .sq      (sq),
    .armed   (armed)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Advance one clock edge; outputs are sampled 1ns after it.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset    = 1'b1;
    cfg_we   = 1'b0;
    cfg_ch   = '0;
    cfg_div  = '0;
    cfg_mode = PERIODIC;
    ch_en    = '0;
    step_req = '0;
    cyc();
    cyc();
    check("rst_tick",  32'(tick),  32'h0);
    check("rst_sq",    32'(sq),    32'h0);
    check("rst_armed", 32'(armed), 32'h0);

    // Default divisor 4 on channel 0: ticks on cycles 4, 8, 12.
    reset = 1'b0;
    ch_en = 4'b0001;
    for (int c = 1; c <= 12; c++) begin
      cyc();
      check("p4_tick", 32'(tick), (c % 4 == 0) ? 32'h1 : 32'h0);
      check("p4_sq",   32'(sq[0]), 32'((c / 4) & 1));
    end

    // Channel 1, div=0 periodic: write cycle itself gives no tick.
    ch_en    = 4'b0010;
    cfg_we   = 1'b1;
    cfg_ch   = 4'd1;
    cfg_div  = 32'd0;
    cfg_mode = PERIODIC;
    cyc();
    cfg_we = 1'b0;
    check("d0_wr_tick", 32'(tick), 32'h0);
    check("d0_sq0_kept", 32'(sq[0]), 32'h1);
    for (int k = 1; k <= 4; k++) begin
      cyc();
      check("d0_tick", 32'(tick), 32'h2);
      check("d0_sq",   32'(sq[1]), 32'(k & 1));
    end

    // Channel 2 one-shot, div=3.
    ch_en    = 4'b0100;
    cfg_we   = 1'b1;
    cfg_ch   = 4'd2;
    cfg_div  = 32'd3;
    cfg_mode = ONESHOT;
    cyc();
    cfg_we   = 1'b0;
    check("os_idle_armed", 32'(armed), 32'h0);
    step_req = 4'b0100;
    cyc();
    step_req = 4'b0000;
    check("os_armed", 32'(armed), 32'h4);
    check("os_arm_tick", 32'(tick), 32'h0);
    for (int k = 1; k <= 7; k++) begin
      cyc();
      check("os_tick",  32'(tick),  (k == 3) ? 32'h4 : 32'h0);
      check("os_armed", 32'(armed), (k < 3) ? 32'h4 : 32'h0);
    end
    // Retrigger at count 1.
    step_req = 4'b0100;
    cyc();
    step_req = 4'b0000;
    cyc();
    check("rt_cnt1_tick", 32'(tick), 32'h0);
    step_req = 4'b0100;
    cyc();
    step_req = 4'b0000;
    check("rt_re_tick",  32'(tick),  32'h0);
    check("rt_re_armed", 32'(armed), 32'h4);
    for (int k = 1; k <= 4; k++) begin
      cyc();
      check("rt_tick", 32'(tick), (k == 3) ? 32'h4 : 32'h0);
    end
    check("rt_disarmed", 32'(armed), 32'h0);

    // Channel 3 step mode, step_req held high for 5 cycles.
    ch_en    = 4'b1000;
    cfg_we   = 1'b1;
    cfg_ch   = 4'd3;
    cfg_div  = 32'd7;
    cfg_mode = STEP;
    cyc();
    cfg_we   = 1'b0;
    step_req = 4'b1000;
    for (int k = 1; k <= 5; k++) begin
      cyc();
      check("st_tick", 32'(tick), (k == 1) ? 32'h8 : 32'h0);
    end
    step_req = 4'b0000;
    cyc();
    check("st_release", 32'(tick), 32'h0);
    check("st_sq", 32'(sq[3]), 32'h1);

    // Channel 0 div=5; rewrite lands on terminal count 4.
    ch_en    = 4'b1001;
    cfg_we   = 1'b1;
    cfg_ch   = 4'd0;
    cfg_div  = 32'd5;
    cfg_mode = PERIODIC;
    cyc();
    cfg_we = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      cyc();
      check("wt_pre_tick", 32'(tick), 32'h0);
    end
    cfg_we = 1'b1;
    cyc();
    cfg_we = 1'b0;
    check("wt_win_tick", 32'(tick), 32'h0);
    check("wt_win_sq",   32'(sq[0]), 32'h1);
    for (int k = 1; k <= 5; k++) begin
      cyc();
      check("wt_tick", 32'(tick), (k == 5) ? 32'h1 : 32'h0);
    end
    check("wt_sq", 32'(sq[0]), 32'h0);
    // Out-of-range channel 15 must not alter anything.
    cfg_we   = 1'b1;
    cfg_ch   = 4'd15;
    cfg_div  = 32'd1;
    cfg_mode = PERIODIC;
    for (int k = 1; k <= 5; k++) begin
      cyc();
      cfg_we = 1'b0;
      check("oor_tick", 32'(tick), (k == 5) ? 32'h1 : 32'h0);
    end
    check("oor_armed", 32'(armed), 32'h0);

    // Reset mid-count with channel 2 re-armed.
    cfg_we   = 1'b1;
    cfg_ch   = 4'd2;
    cfg_div  = 32'd3;
    cfg_mode = ONESHOT;
    cyc();
    cfg_we   = 1'b0;
    ch_en    = 4'b1111;
    step_req = 4'b0100;
    cyc();
    step_req = 4'b0000;
    cyc();
    check("pre_rst_armed", 32'(armed), 32'h4);
    reset = 1'b1;
    cyc();
    check("mid_rst_tick",  32'(tick),  32'h0);
    check("mid_rst_sq",    32'(sq),    32'h0);
    check("mid_rst_armed", 32'(armed), 32'h0);
    reset = 1'b0;
    // All channels back to PERIODIC with divisor 4.
    for (int k = 1; k <= 8; k++) begin
      cyc();
      check("post_rst_tick", 32'(tick), (k % 4 == 0) ? 32'hF : 32'h0);
      check("post_rst_sq",   32'(sq),   ((k / 4) & 1) ? 32'hF : 32'h0);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
